// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences multi-pass shift commands through an external 4-bit barrel shifter,
// looping each pass result back as the next operand and presenting the final word on valid/ready.
module shift_seq_ctrl #(
    parameter int AMT_W    = 3,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic [3:0]       sh_data,
    output logic [1:0]       sh_amt,
    output logic             sh_dir,
    output logic [1:0]       sh_mode,
    input  logic [3:0]       sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       acc, acc_nx;
    logic [AMT_W-1:0] rem, rem_nx;
    logic             dir, dir_nx, err, err_nx, accept;
    logic [1:0]       mode, mode_nx, step;

    assign in_ready = (state == IDLE) | (state == DONE & out_ready);
    assign accept   = in_valid & in_ready;
    // Arithmetic right is issued one position per pass so sign fill is applied on every pass.
    assign step = (mode == 2'b10 && dir) ? 2'd1 :
                  (rem > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : 2'(rem);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        rem_nx   = rem;
        dir_nx   = dir;
        mode_nx  = mode;
        err_nx   = err;
        if (state == RUN) begin
            acc_nx   = sh_result;
            rem_nx   = rem - AMT_W'(step);
            state_nx = (rem == AMT_W'(step)) ? DONE : RUN;
        end
        if (state == DONE && out_ready)
            state_nx = IDLE;
        if (accept) begin
            acc_nx   = (&in_mode) ? 4'd0 : in_data;
            rem_nx   = in_amt;
            dir_nx   = in_dir;
            mode_nx  = in_mode;
            err_nx   = &in_mode;
            state_nx = (&in_mode || in_amt == '0) ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            mode  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            rem   <= rem_nx;
            dir   <= dir_nx;
            mode  <= mode_nx;
            err   <= err_nx;
        end
    end

    assign sh_data   = acc;
    assign sh_amt    = (state == RUN) ? step : 2'd0;
    assign sh_dir    = dir;
    assign sh_mode   = mode;
    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? acc : 4'd0;
    assign out_err   = out_valid & err;
    assign busy      = (state != IDLE);
endmodule
